mc_run_ctrl: RTL and testbench

Synthesizable run controller for the multicycle MIPS core. It sequences the core's reset and watches the core's `ans` result bus until a completion condition or a timeout occurs. It then reports pass/fail, the cycle count and the final answer. It replaces free-running, hand-timed reset stimulus, and one instance serves both simulation and FPGA bring-up.

---
 rtl/mc_run_pkg.sv | 14 +
 rtl/mc_stable_detect.sv | 49 ++++
 rtl/mc_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_mc_run_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_run_pkg.sv
// Shared types and constants for the multicycle-core run controller.
package mc_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam int unsigned MODE_MATCH  = 0;
  localparam int unsigned MODE_STABLE = 1;

endpackage

// File: rtl/mc_stable_detect.sv
// Tracks how many consecutive samples of ans repeated the previous one;
// stable_c flags the sample that completes the required run of repeats.
module mc_stable_detect #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [DATA_W-1:0] ans,
  output logic              stable_c
);

  localparam int unsigned SC_W = $clog2(STABLE_CYCLES + 1);

  logic [DATA_W-1:0] prev_q;
  logic [SC_W-1:0]   cnt_q;
  logic [SC_W-1:0]   cnt_d;

  // clear wins so the first sample after entry never counts against stale prev_q
  always_comb begin : p_cnt_next
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (ans != prev_q) begin
        cnt_d = '0;
      end else if (cnt_q != SC_W'(STABLE_CYCLES)) begin
        cnt_d = cnt_q + SC_W'(1);
      end
    end
  end

  assign stable_c = en && (cnt_d == SC_W'(STABLE_CYCLES));

  always_ff @(posedge ph1 or negedge reset) begin : p_regs
    if (!reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        prev_q <= ans;
      end
    end
  end

endmodule

// File: rtl/mc_run_ctrl.sv
// Run controller for the multicycle MIPS core: sequences core reset, watches
// ans for completion or timeout, and reports pass/fail, cycle count and answer.
module mc_run_ctrl
  import mc_run_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned TIMEOUT       = 1000,
  parameter int unsigned MODE          = 0,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] ans,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycles,
  output logic [DATA_W-1:0] ans_final
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("mc_run_ctrl: HOLD_CYCLES must be >= 1");
  end
  if ((TIMEOUT < 1) || (64'(TIMEOUT) >= (64'd1 << CNT_W))) begin : g_bad_timeout
    $error("mc_run_ctrl: TIMEOUT must be in 1..2^CNT_W-1");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("mc_run_ctrl: STABLE_CYCLES must be >= 1");
  end
  if ((MODE != MODE_MATCH) && (MODE != MODE_STABLE)) begin : g_bad_mode
    $error("mc_run_ctrl: MODE must be 0 (MATCH) or 1 (STABLE)");
  end

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d, cyc_inc;
  logic [DATA_W-1:0] ansf_q, ansf_d;
  logic              core_reset_q, core_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;
  logic              det_en_c, det_clear_c, stable_c, complete_c;

  // cycles_q is still zero on the first RUN edge, when prev_ans holds nothing useful
  assign det_en_c    = (state_q == ST_RUN);
  assign det_clear_c = (state_q != ST_RUN) || (cycles_q == '0);

  mc_stable_detect #(
    .DATA_W        (DATA_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable (
    .ph1      (ph1),
    .reset    (reset),
    .en       (det_en_c),
    .clear    (det_clear_c),
    .ans      (ans),
    .stable_c (stable_c)
  );

  assign complete_c = (MODE == MODE_STABLE) ? stable_c : (ans == expected);
  assign cyc_inc    = cycles_q + CNT_W'(1);

  always_comb begin : p_next
    state_d   = state_q;
    hold_d    = hold_q;
    cycles_d  = cycles_q;
    done_d    = done_q;
    pass_d    = pass_q;
    to_d      = to_q;
    ansf_d    = ansf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_HOLD;
          hold_d   = '0;
          cycles_d = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          to_d     = 1'b0;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cycles_d = cyc_inc;
        // completion takes priority over a coincident timeout
        if (complete_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (ans == expected);
          ansf_d  = ans;
        end else if (cyc_inc == CNT_W'(TIMEOUT)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          to_d    = 1'b1;
          ansf_d  = ans;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    running_d    = (state_d == ST_HOLD) || (state_d == ST_RUN);
  end

  always_ff @(posedge ph1 or negedge reset) begin : p_regs
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      cycles_q     <= '0;
      ansf_q       <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycles_q     <= cycles_d;
      ansf_q       <= ansf_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      to_q         <= to_d;
    end
  end

  assign core_reset = core_reset_q;
  assign running    = running_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timed_out  = to_q;
  assign cycles     = cycles_q;
  assign ans_final  = ansf_q;

endmodule

// File: tb/tb_mc_run_ctrl.sv
// Directed bench for mc_run_ctrl: one MATCH-mode and one STABLE-mode instance
// share inputs; each test checks the instance whose mode it exercises.
module tb_mc_run_ctrl;

  logic       ph1;
  logic       reset;
  logic       start;
  logic [7:0] expected;
  logic [7:0] ans;

  logic        m_core_reset, m_running, m_done, m_pass, m_to;
  logic [15:0] m_cycles;
  logic [7:0]  m_ansf;
  logic        s_core_reset, s_running, s_done, s_pass, s_to;
  logic [15:0] s_cycles;
  logic [7:0]  s_ansf;

  int errors = 0;
  int checks = 0;

  mc_run_ctrl #(
    .DATA_W(8), .CNT_W(16), .HOLD_CYCLES(2), .TIMEOUT(20), .MODE(0), .STABLE_CYCLES(4)
  ) u_match (
    .ph1(ph1), .reset(reset), .start(start), .expected(expected), .ans(ans),
    .core_reset(m_core_reset), .running(m_running), .done(m_done), .pass(m_pass),
    .timed_out(m_to), .cycles(m_cycles), .ans_final(m_ansf)
  );

  mc_run_ctrl #(
    .DATA_W(8), .CNT_W(16), .HOLD_CYCLES(2), .TIMEOUT(20), .MODE(1), .STABLE_CYCLES(4)
  ) u_stable (
    .ph1(ph1), .reset(reset), .start(start), .expected(expected), .ans(ans),
    .core_reset(s_core_reset), .running(s_running), .done(s_done), .pass(s_pass),
    .timed_out(s_to), .cycles(s_cycles), .ans_final(s_ansf)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  // start edge plus the two hold edges; afterwards the next edge is RUN edge 1
  task automatic run_to_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ans = 8'h00; expected = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_core_reset !== 1'b1 || m_running !== 1'b0 || m_done !== 1'b0 || m_cycles !== 16'd0 ||
          s_core_reset !== 1'b1 || s_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: core_reset=%b running=%b done=%b cycles=%0d, want 1 0 0 0",
                 i, m_core_reset, m_running, m_done, m_cycles);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_core_reset !== 1'b1 || m_running !== 1'b0 || m_done !== 1'b0 || m_cycles !== 16'd0) begin
        errors++;
        $display("FAIL idle_no_start[%0d]: core_reset=%b running=%b done=%b cycles=%0d, want 1 0 0 0",
                 i, m_core_reset, m_running, m_done, m_cycles);
      end
    end
  endtask

  task automatic test_match_pass();
    expected = 8'h0D; ans = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (m_core_reset !== 1'b1 || m_running !== 1'b1) begin
      errors++;
      $display("FAIL hold_edge0: core_reset=%b running=%b, want 1 1", m_core_reset, m_running);
    end
    tick();
    checks++;
    if (m_core_reset !== 1'b1) begin
      errors++;
      $display("FAIL hold_edge1: core_reset=%b, want 1", m_core_reset);
    end
    tick();
    checks++;
    if (m_core_reset !== 1'b0 || m_running !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: core_reset=%b running=%b, want 0 1", m_core_reset, m_running);
    end
    for (int k = 1; k <= 7; k++) begin
      ans = (k == 7) ? 8'h0D : 8'h00;
      tick();
      if (k < 7) begin
        checks++;
        if (m_done !== 1'b0) begin
          errors++;
          $display("FAIL match_early_done at run edge %0d: done=%b, want 0", k, m_done);
        end
      end
    end
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_to !== 1'b0) begin
      errors++;
      $display("FAIL match_status: done=%b pass=%b timed_out=%b, want 1 1 0", m_done, m_pass, m_to);
    end
    checks++;
    if (m_cycles !== 16'd7 || m_ansf !== 8'h0D) begin
      errors++;
      $display("FAIL match_result: cycles=%0d ans_final=%h, want 7 0d", m_cycles, m_ansf);
    end
    checks++;
    if (m_running !== 1'b0 || m_core_reset !== 1'b0) begin
      errors++;
      $display("FAIL match_done_ctrl: running=%b core_reset=%b, want 0 0", m_running, m_core_reset);
    end
  endtask

  task automatic test_timeout();
    expected = 8'h0D; ans = 8'h05;
    run_to_run();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 19) begin
        checks++;
        if (m_done !== 1'b0 || m_cycles !== 16'd19) begin
          errors++;
          $display("FAIL timeout_early: done=%b cycles=%0d, want 0 19", m_done, m_cycles);
        end
      end
    end
    checks++;
    if (m_done !== 1'b1 || m_to !== 1'b1 || m_pass !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: done=%b timed_out=%b pass=%b, want 1 1 0", m_done, m_to, m_pass);
    end
    checks++;
    if (m_cycles !== 16'd20 || m_ansf !== 8'h05) begin
      errors++;
      $display("FAIL timeout_result: cycles=%0d ans_final=%h, want 20 05", m_cycles, m_ansf);
    end
    tick();
    checks++;
    if (m_cycles !== 16'd20 || m_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_frozen: cycles=%0d done=%b, want 20 1", m_cycles, m_done);
    end
    // match landing on the timeout edge
    run_to_run();
    for (int k = 1; k <= 20; k++) begin
      ans = (k == 20) ? 8'h0D : 8'h05;
      tick();
    end
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tie_status: done=%b pass=%b timed_out=%b, want 1 1 0", m_done, m_pass, m_to);
    end
    checks++;
    if (m_cycles !== 16'd20 || m_ansf !== 8'h0D) begin
      errors++;
      $display("FAIL timeout_tie_result: cycles=%0d ans_final=%h, want 20 0d", m_cycles, m_ansf);
    end
  endtask

  task automatic test_start_ignored();
    expected = 8'h0D; ans = 8'h00;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if (m_core_reset !== 1'b1) begin
      errors++;
      $display("FAIL ign_hold1: core_reset=%b, want 1", m_core_reset);
    end
    tick();
    checks++;
    if (m_core_reset !== 1'b0 || m_running !== 1'b1) begin
      errors++;
      $display("FAIL ign_run_entry: core_reset=%b running=%b, want 0 1", m_core_reset, m_running);
    end
    for (int k = 1; k <= 5; k++) begin
      start = (k <= 3) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (m_cycles !== 16'(k) || m_running !== 1'b1) begin
        errors++;
        $display("FAIL ign_cycles at run edge %0d: cycles=%0d running=%b, want %0d 1",
                 k, m_cycles, m_running, k);
      end
    end
    ans = 8'h0D;
    tick();
    checks++;
    if (m_done !== 1'b1 || m_cycles !== 16'd6 || m_pass !== 1'b1) begin
      errors++;
      $display("FAIL ign_done: done=%b cycles=%0d pass=%b, want 1 6 1", m_done, m_cycles, m_pass);
    end
    // restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (m_done !== 1'b0 || m_pass !== 1'b0 || m_to !== 1'b0 || m_core_reset !== 1'b1 || m_cycles !== 16'd0) begin
      errors++;
      $display("FAIL restart_clear: done=%b pass=%b timed_out=%b core_reset=%b cycles=%0d, want 0 0 0 1 0",
               m_done, m_pass, m_to, m_core_reset, m_cycles);
    end
    tick();
    checks++;
    if (m_core_reset !== 1'b1) begin
      errors++;
      $display("FAIL restart_hold1: core_reset=%b, want 1", m_core_reset);
    end
    tick();
    checks++;
    if (m_core_reset !== 1'b0) begin
      errors++;
      $display("FAIL restart_run: core_reset=%b, want 0", m_core_reset);
    end
    for (int k = 1; k <= 5; k++) tick();
    checks++;
    if (m_done !== 1'b1 || m_cycles !== 16'd1) begin
      errors++;
      $display("FAIL restart_done: done=%b cycles=%0d, want 1 1", m_done, m_cycles);
    end
  endtask

  task automatic test_stable();
    logic [7:0] seq [6];
    seq[0] = 8'h03; seq[1] = 8'h05; seq[2] = 8'h05;
    seq[3] = 8'h05; seq[4] = 8'h05; seq[5] = 8'h05;
    for (int pass_run = 0; pass_run < 2; pass_run++) begin
      expected = (pass_run == 0) ? 8'h05 : 8'h07;
      ans = 8'h00;
      run_to_run();
      for (int k = 0; k < 6; k++) begin
        ans = seq[k];
        tick();
        if (k < 5) begin
          checks++;
          if (s_done !== 1'b0) begin
            errors++;
            $display("FAIL stable_early[%0d] at run edge %0d: done=%b, want 0", pass_run, k + 1, s_done);
          end
        end
      end
      checks++;
      if (s_done !== 1'b1 || s_pass !== (pass_run == 0) || s_to !== 1'b0) begin
        errors++;
        $display("FAIL stable_status[%0d]: done=%b pass=%b timed_out=%b, want 1 %0d 0",
                 pass_run, s_done, s_pass, s_to, (pass_run == 0));
      end
      checks++;
      if (s_cycles !== 16'd6 || s_ansf !== 8'h05) begin
        errors++;
        $display("FAIL stable_result[%0d]: cycles=%0d ans_final=%h, want 6 05", pass_run, s_cycles, s_ansf);
      end
    end
    // let the MATCH instance finish too
    ans = 8'h07;
    tick();
  endtask

  task automatic test_reset_midrun();
    expected = 8'h0D; ans = 8'h00;
    run_to_run();
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if (m_cycles !== 16'd4 || m_running !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre: cycles=%0d running=%b, want 4 1", m_cycles, m_running);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (m_core_reset !== 1'b1 || m_running !== 1'b0 || m_cycles !== 16'd0 || m_done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async: core_reset=%b running=%b cycles=%0d done=%b, want 1 0 0 0",
               m_core_reset, m_running, m_cycles, m_done);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (m_core_reset !== 1'b1 || m_running !== 1'b0 || m_done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: core_reset=%b running=%b done=%b, want 1 0 0", m_core_reset, m_running, m_done);
    end
    run_to_run();
    ans = 8'h0D;
    tick();
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_cycles !== 16'd1 || m_ansf !== 8'h0D) begin
      errors++;
      $display("FAIL midrun_recover: done=%b pass=%b cycles=%0d ans_final=%h, want 1 1 1 0d",
               m_done, m_pass, m_cycles, m_ansf);
    end
  endtask

  initial begin
    test_reset();
    test_match_pass();
    test_timeout();
    test_start_ignored();
    test_stable();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
